// File: rtl/aes_io_pkg.sv
// Shared types and constants for the host-side AES I/O bridge.
package aes_io_pkg;

    localparam int WORDS_PER_BLOCK = 4;
    localparam int WORD_IDX_W      = 2;

    typedef enum logic [2:0] {
        LOAD_KEY = 3'd0,
        LOAD_MSG = 3'd1,
        WAIT_AES = 3'd2,
        UNLOAD   = 3'd3,
        RECYCLE  = 3'd4,
        ERROR    = 3'd5
    } state_e;

endpackage

// File: rtl/aes_word_packer.sv
// Four-word block register: shifts host words in MSW-first, loads a whole
// block at once, and presents any word (index 0 = bits [127:96]) for readout.
module aes_word_packer
    import aes_io_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int BLOCK_W = 128
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  shift_en,
    input  logic [DATA_W-1:0]     shift_word,
    input  logic                  load_en,
    input  logic [BLOCK_W-1:0]    load_block,
    input  logic [WORD_IDX_W-1:0] sel,
    output logic [BLOCK_W-1:0]    block_out,
    output logic [DATA_W-1:0]     word_out
);

    // words_q[3] holds bits [127:96], i.e. the first word on the wire.
    logic [WORDS_PER_BLOCK-1:0][DATA_W-1:0] words_q, words_d;

    always_comb begin
        words_d = words_q;
        if (load_en) begin
            words_d = load_block;
        end else if (shift_en) begin
            words_d = {words_q[WORDS_PER_BLOCK-2:0], shift_word};
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            words_q <= '0;
        end else begin
            words_q <= words_d;
        end
    end

    assign block_out = words_q;
    assign word_out  = words_q[~sel];

endmodule

// File: rtl/aes_io_bridge.sv
// Host stream <-> AES decryption controller bridge: collects key and
// ciphertext, waits (with watchdog) for the result, streams it back, re-arms.
module aes_io_bridge
    import aes_io_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int BLOCK_W = 128,
    parameter int TIMEOUT = 1024
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [DATA_W-1:0]  in_data,
    input  logic               in_valid,
    output logic               in_ready,
    output logic [DATA_W-1:0]  out_data,
    output logic               out_valid,
    input  logic               out_ready,
    input  logic               abort,
    output logic               err,
    output logic [BLOCK_W-1:0] key,
    output logic [BLOCK_W-1:0] msg_en,
    output logic               io_ready,
    input  logic [BLOCK_W-1:0] msg_de,
    input  logic               aes_ready,
    output logic               aes_reset_n
);

    localparam int WD_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    state_e                state_q, state_d;
    logic [WORD_IDX_W-1:0] cnt_q, cnt_d;
    logic [WD_W-1:0]       wd_q, wd_d;
    logic                  in_xfer, out_xfer, last_word, wd_expired;
    logic [DATA_W-1:0]     key_word_unused, msg_word_unused;
    logic [BLOCK_W-1:0]    out_block_unused;

    assign in_xfer    = in_valid & in_ready;
    // A read coincident with abort is discarded by the host, so it must not advance.
    assign out_xfer   = out_valid & out_ready & ~abort;
    assign last_word  = (cnt_q == WORD_IDX_W'(WORDS_PER_BLOCK - 1));
    assign wd_expired = (TIMEOUT != 0) && (wd_q == WD_W'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= LOAD_KEY;
            cnt_q   <= '0;
            wd_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wd_q    <= wd_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        wd_d    = wd_q;
        case (state_q)
            LOAD_KEY: if (in_xfer) begin
                cnt_d = cnt_q + 1'b1;
                if (last_word) state_d = LOAD_MSG;
            end
            LOAD_MSG: if (in_xfer) begin
                cnt_d = cnt_q + 1'b1;
                if (last_word) begin
                    state_d = WAIT_AES;
                    wd_d    = '0;
                end
            end
            WAIT_AES: begin
                wd_d = wd_q + 1'b1;
                if (aes_ready) begin
                    state_d = UNLOAD;
                    cnt_d   = '0;
                end else if (wd_expired) begin
                    state_d = ERROR;
                end
            end
            UNLOAD: if (out_xfer) begin
                cnt_d = cnt_q + 1'b1;
                if (last_word) state_d = RECYCLE;
            end
            RECYCLE: begin
                cnt_d   = '0;
                wd_d    = '0;
                state_d = LOAD_KEY;
            end
            ERROR:   state_d = ERROR;
            default: state_d = LOAD_KEY;
        endcase
        if (abort) state_d = RECYCLE;
    end

    always_comb begin
        in_ready    = reset_n & ~abort & ((state_q == LOAD_KEY) | (state_q == LOAD_MSG));
        out_valid   = reset_n & (state_q == UNLOAD);
        io_ready    = reset_n & (state_q == WAIT_AES);
        err         = reset_n & (state_q == ERROR);
        aes_reset_n = reset_n & (state_q != RECYCLE);
    end

    aes_word_packer #(.DATA_W(DATA_W), .BLOCK_W(BLOCK_W)) u_key_buf (
        .clk        (clk),
        .reset_n    (reset_n),
        .shift_en   (in_xfer & (state_q == LOAD_KEY)),
        .shift_word (in_data),
        .load_en    (1'b0),
        .load_block ('0),
        .sel        ('0),
        .block_out  (key),
        .word_out   (key_word_unused)
    );

    aes_word_packer #(.DATA_W(DATA_W), .BLOCK_W(BLOCK_W)) u_msg_buf (
        .clk        (clk),
        .reset_n    (reset_n),
        .shift_en   (in_xfer & (state_q == LOAD_MSG)),
        .shift_word (in_data),
        .load_en    (1'b0),
        .load_block ('0),
        .sel        ('0),
        .block_out  (msg_en),
        .word_out   (msg_word_unused)
    );

    aes_word_packer #(.DATA_W(DATA_W), .BLOCK_W(BLOCK_W)) u_out_buf (
        .clk        (clk),
        .reset_n    (reset_n),
        .shift_en   (1'b0),
        .shift_word ('0),
        .load_en    ((state_q == WAIT_AES) & aes_ready),
        .load_block (msg_de),
        .sel        (cnt_q),
        .block_out  (out_block_unused),
        .word_out   (out_data)
    );

endmodule

// File: tb/tb_aes_io_bridge.sv
// Scoreboard bench for aes_io_bridge with a behavioural AES controller stand-in.
module tb_aes_io_bridge;
    import aes_io_pkg::*;

    localparam int TO = 16;
    localparam int STUB_LAT = 5;

    localparam logic [127:0] KEY_A = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] CT_A  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] PT_A  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] KEY_B = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic [31:0]  in_data = '0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [31:0]  out_data;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic         abort = 1'b0;
    logic         err;
    logic [127:0] key, msg_en;
    logic         io_ready;
    logic [127:0] msg_de = '0;
    logic         aes_ready = 1'b0;
    logic         aes_reset_n;

    int n_checks = 0;
    int n_fail = 0;
    logic [31:0] exp_q[$];
    bit stub_hang = 1'b0;
    int stub_cnt = 0;

    always #5 clk = ~clk;

    aes_io_bridge #(.DATA_W(32), .BLOCK_W(128), .TIMEOUT(TO)) dut (
        .clk(clk), .reset_n(reset_n),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .abort(abort), .err(err),
        .key(key), .msg_en(msg_en), .io_ready(io_ready),
        .msg_de(msg_de), .aes_ready(aes_ready), .aes_reset_n(aes_reset_n)
    );

    function automatic logic [127:0] stub_decrypt(input logic [127:0] k, input logic [127:0] c);
        if (k == KEY_A && c == CT_A) return PT_A;
        if (k == KEY_B && c == CT_B) return PT_B;
        return 128'hdeaddeaddeaddeaddeaddeaddeaddead;
    endfunction

    // Controller stand-in: answers STUB_LAT cycles into io_ready, parks until reset.
    always @(posedge clk) begin
        if (!aes_reset_n) begin
            aes_ready <= 1'b0;
            stub_cnt  <= 0;
        end else if (io_ready && !aes_ready && !stub_hang) begin
            if (stub_cnt == STUB_LAT) begin
                aes_ready <= 1'b1;
                msg_de    <= stub_decrypt(key, msg_en);
            end else begin
                stub_cnt <= stub_cnt + 1;
            end
        end
    end

    function automatic logic [31:0] word_of(input logic [127:0] blk, input int i);
        return blk[127-32*i -: 32];
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end else begin
            $display("ok   %s: %h", name, act);
        end
    endtask

    // Monitor: every accepted output word is popped and compared.
    always @(negedge clk) begin
        if (reset_n && out_valid && out_ready && !abort) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL out_unexpected: got %h expected no word", out_data);
            end else begin
                check("out_word", 128'(out_data), 128'(exp_q.pop_front()));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input logic [127:0] pt);
        for (int i = 0; i < 4; i++) exp_q.push_back(word_of(pt, i));
    endtask

    task automatic send_word(input logic [31:0] w, input bit toggle);
        int n;
        bit ok;
        if (toggle) begin
            in_valid = 1'b0;
            tick();
        end
        in_data  = w;
        in_valid = 1'b1;
        n = 0;
        ok = 1'b0;
        while (!ok && n < 100) begin
            ok = in_ready;
            tick();
            n++;
        end
        in_valid = 1'b0;
        if (!ok) check("in_accept_timeout", 128'(0), 128'(1));
    endtask

    task automatic load_job(input logic [127:0] k, input logic [127:0] m, input bit toggle);
        for (int i = 0; i < 4; i++) send_word(word_of(k, i), toggle);
        for (int i = 0; i < 3; i++) send_word(word_of(m, i), toggle);
        check("io_ready_before_last", 128'(io_ready), 128'(0));
        send_word(word_of(m, 3), toggle);
        check("io_ready_after_last", 128'(io_ready), 128'(1));
    endtask

    task automatic recv_block(input bit stall);
        int n;
        logic [31:0] d;
        for (int w = 0; w < 4; w++) begin
            n = 0;
            while (!out_valid && n < 100) begin
                tick();
                n++;
            end
            if (!out_valid) begin
                check("out_valid_timeout", 128'(0), 128'(1));
                return;
            end
            check("in_ready_in_unload", 128'(in_ready), 128'(0));
            if (stall) begin
                d = out_data;
                for (int s = 0; s < 5; s++) begin
                    tick();
                    check("out_hold", {95'(0), out_valid, out_data}, {95'(0), 1'b1, d});
                end
            end
            out_ready = 1'b1;
            tick();
            out_ready = 1'b0;
        end
        check("recycle_aes_reset_n", 128'(aes_reset_n), 128'(0));
        check("recycle_in_ready", 128'(in_ready), 128'(0));
        tick();
        check("rearm_aes_reset_n", 128'(aes_reset_n), 128'(1));
        check("rearm_in_ready", 128'(in_ready), 128'(1));
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    initial begin
        int n;
        // Reset state
        reset_n = 1'b0;
        repeat (3) tick();
        check("rst_in_ready", 128'(in_ready), 128'(0));
        check("rst_out_valid", 128'(out_valid), 128'(0));
        check("rst_io_ready", 128'(io_ready), 128'(0));
        check("rst_err", 128'(err), 128'(0));
        check("rst_aes_reset_n", 128'(aes_reset_n), 128'(0));
        check("rst_key", key, 128'(0));
        check("rst_msg_en", msg_en, 128'(0));
        reset_n = 1'b1;
        #1;
        check("post_rst_in_ready", 128'(in_ready), 128'(1));
        check("post_rst_aes_reset_n", 128'(aes_reset_n), 128'(1));

        // FIPS-197 C.1 decrypt
        push_exp(PT_A);
        load_job(KEY_A, CT_A, 1'b0);
        check("key_a", key, KEY_A);
        check("msg_a", msg_en, CT_A);
        recv_block(1'b0);

        // Back-to-back second job with the same key and ciphertext
        push_exp(PT_A);
        load_job(KEY_A, CT_A, 1'b0);
        recv_block(1'b0);

        // Input toggling and output backpressure
        push_exp(PT_A);
        load_job(KEY_A, CT_A, 1'b1);
        recv_block(1'b1);

        // Watchdog expiry with a silent controller
        stub_hang = 1'b1;
        load_job(KEY_A, CT_A, 1'b0);
        for (int k = 1; k <= 16; k++) begin
            tick();
            if (k == 15) check("wd_err_before", 128'(err), 128'(0));
        end
        check("wd_err_at_16", 128'(err), 128'(1));
        check("wd_io_ready_drop", 128'(io_ready), 128'(0));
        check("wd_in_ready", 128'(in_ready), 128'(0));
        repeat (3) tick();
        check("wd_err_sticky", 128'(err), 128'(1));
        check("wd_out_valid", 128'(out_valid), 128'(0));
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("wd_abort_err_clear", 128'(err), 128'(0));
        check("wd_abort_recycle", 128'(aes_reset_n), 128'(0));
        tick();
        check("wd_abort_load_key", 128'(in_ready), 128'(1));
        stub_hang = 1'b0;

        // Abort after two message words, with a word on offer
        for (int i = 0; i < 4; i++) send_word(word_of(KEY_B, i), 1'b0);
        for (int i = 0; i < 2; i++) send_word(word_of(CT_B, i), 1'b0);
        in_data  = word_of(CT_B, 2);
        in_valid = 1'b1;
        abort    = 1'b1;
        #1;
        check("abort_in_ready", 128'(in_ready), 128'(0));
        tick();
        abort    = 1'b0;
        in_valid = 1'b0;
        check("abort_recycle", 128'(aes_reset_n), 128'(0));
        check("abort_word_dropped", 128'(msg_en[31:0]), 128'(word_of(CT_B, 1)));
        tick();
        check("abort_rearm", 128'(in_ready), 128'(1));
        push_exp(PT_B);
        load_job(KEY_B, CT_B, 1'b0);
        recv_block(1'b0);

        // Reset in the middle of unloading
        push_exp(PT_A);
        load_job(KEY_A, CT_A, 1'b0);
        n = 0;
        while (!out_valid && n < 100) begin
            tick();
            n++;
        end
        check("mid_unload_valid", 128'(out_valid), 128'(1));
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("mid_unload_remaining", 128'(exp_q.size()), 128'(3));
        exp_q.delete();
        reset_n = 1'b0;
        #1;
        check("mid_rst_out_valid", 128'(out_valid), 128'(0));
        check("mid_rst_aes_reset_n", 128'(aes_reset_n), 128'(0));
        tick();
        check("mid_rst_state", 128'(dut.state_q), 128'(LOAD_KEY));
        check("mid_rst_out_buf", 128'(dut.u_out_buf.words_q), 128'(0));
        check("mid_rst_out_valid_held", 128'(out_valid), 128'(0));
        reset_n = 1'b1;
        #1;
        check("mid_rst_release_in_ready", 128'(in_ready), 128'(1));

        tick();
        check("scoreboard_empty", 128'(exp_q.size()), 128'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
